// File: rtl/hexdisp_pkg.sv
// hexdisp_pkg: register map, control-field positions and hex glyph table
// shared by the seven-segment display controller.
package hexdisp_pkg;
    localparam logic [1:0] REG_VALUE  = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam int CTRL_EN_LSB    = 0;
    localparam int CTRL_BLINK_LSB = 8;
    localparam int CTRL_LZS_BIT   = 16;
    localparam logic [6:0] BLANK      = 7'b1111111;
    localparam logic [6:0] GLYPH_ZERO = 7'b1000000;

    // Active-low segments, bit order g..a; b and d are lowercase.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction
endpackage

// File: rtl/hexdisp_ctrl_seg7_decode.sv
// seg7_decode: nibble plus blank qualifier to seven active-low segments.
module seg7_decode
    import hexdisp_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    assign seg_o = blank_i ? BLANK : glyph(nib_i);
endmodule

// File: rtl/hexdisp_ctrl.sv
// hexdisp_ctrl: bus-writable seven-segment controller with enable, blink,
// leading-zero suppression and optional multiplexed (scanned) output.
module hexdisp_ctrl
    import hexdisp_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int BLINK_DIV = 25000000,
    parameter int SCAN_MODE = 0,
    parameter int SCAN_DIV  = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          address,
    input  logic                write,
    input  logic [31:0]         writedata,
    input  logic                read,
    output logic [31:0]         readdata,
    output logic [DIGITS*7-1:0] seg,
    output logic [6:0]          seg_mux,
    output logic [DIGITS-1:0]   digit_sel_n
);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int SW = $clog2(SCAN_DIV);

    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   en_q, en_d, blink_q, blink_d, sel_q, sel_d, blank;
    logic                lzs_q, lzs_d, phase_q, phase_d, zero_above, blink_wrap, scan_wrap;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic [SW-1:0]       scnt_q, scnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [DIGITS*7-1:0] seg_q, seg_d, dec;
    logic [6:0]          mux_q, mux_d, dec_mux;

    // Walk from the top digit down so zero_above covers nibbles i..DIGITS-1.
    always_comb begin
        zero_above = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (value_q[4*i +: 4] == 4'd0);
            blank[i] = !en_q[i] || (blink_q[i] && phase_q) || (lzs_q && i != 0 && zero_above);
        end
    end

    generate
        if (SCAN_MODE != 0) begin : g_scan
            logic [31:0] val_pad;
            logic [7:0]  blank_pad;
            assign val_pad   = 32'(value_q);
            assign blank_pad = 8'(blank);
            seg7_decode u_dec (.nib_i(val_pad[{idx_q, 2'b00} +: 4]), .blank_i(blank_pad[idx_q]), .seg_o(dec_mux));
            assign dec = '1;
        end else begin : g_static
            for (genvar g = 0; g < DIGITS; g++) begin : g_dig
                seg7_decode u_dec (.nib_i(value_q[4*g +: 4]), .blank_i(blank[g]), .seg_o(dec[7*g +: 7]));
            end
            assign dec_mux = BLANK;
        end
    endgenerate

    always_comb begin
        value_d = value_q;
        en_d    = en_q;
        blink_d = blink_q;
        lzs_d   = lzs_q;
        if (write && address == REG_VALUE) value_d = writedata[4*DIGITS-1:0];
        if (write && address == REG_CTRL) begin
            en_d    = writedata[CTRL_EN_LSB +: DIGITS];
            blink_d = writedata[CTRL_BLINK_LSB +: DIGITS];
            lzs_d   = writedata[CTRL_LZS_BIT];
        end
        blink_wrap = bcnt_q == BW'(BLINK_DIV - 1);
        bcnt_d     = blink_wrap ? '0 : bcnt_q + BW'(1);
        phase_d    = phase_q ^ blink_wrap;
        scan_wrap  = scnt_q == SW'(SCAN_DIV - 1);
        scnt_d     = (SCAN_MODE == 0 || scan_wrap) ? '0 : scnt_q + SW'(1);
        idx_d      = SCAN_MODE == 0 ? 3'd0 : !scan_wrap ? idx_q : idx_q == 3'(DIGITS - 1) ? 3'd0 : idx_q + 3'd1;
        rdata_d    = !read ? 32'd0
                   : address == REG_VALUE  ? 32'(value_q)
                   : address == REG_CTRL   ? (32'(en_q) << CTRL_EN_LSB) | (32'(blink_q) << CTRL_BLINK_LSB) | (32'(lzs_q) << CTRL_LZS_BIT)
                   : address == REG_STATUS ? {21'd0, idx_q, 7'd0, phase_q}
                   : 32'd0;
        seg_d = SCAN_MODE != 0 ? '1 : dec;
        mux_d = SCAN_MODE != 0 ? dec_mux : BLANK;
        sel_d = SCAN_MODE != 0 ? ~(DIGITS'(1) << idx_q) : '1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            en_q    <= '1;
            blink_q <= '0;
            lzs_q   <= 1'b0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            scnt_q  <= '0;
            idx_q   <= 3'd0;
            rdata_q <= 32'd0;
            seg_q   <= SCAN_MODE != 0 ? '1 : {DIGITS{GLYPH_ZERO}};
            mux_q   <= BLANK;
            sel_q   <= '1;
        end else begin
            value_q <= value_d;
            en_q    <= en_d;
            blink_q <= blink_d;
            lzs_q   <= lzs_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            scnt_q  <= scnt_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            seg_q   <= seg_d;
            mux_q   <= mux_d;
            sel_q   <= sel_d;
        end
    end

    assign readdata    = rdata_q;
    assign seg         = seg_q;
    assign seg_mux     = mux_q;
    assign digit_sel_n = sel_q;
endmodule
